// File: rtl/exec_stage.sv
// exec_stage: pipeline execute stage with operand forwarding, load-use stall and an iterative multiplier
//
// Ports:
//   Clk, Rst          clock, asynchronous active-high reset
//   Opcode..Out_flag  decoded fields and register operands from stage 1
//   Wb_bus            {data, addr, we} write-back from stage 3
//   Stall             hold stage-1 inputs and the PC this cycle
//   Buf2_*            registered fields for stage 3
//   Flag_z, Flag_c    zero and carry/overflow flags
module exec_stage #(
    parameter int DW  = 8,
    parameter int AW  = 3,
    parameter int OPW = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [OPW-1:0]    Opcode,
    input  logic [DW-1:0]     Op_a,
    input  logic [DW-1:0]     Op_b,
    input  logic [AW-1:0]     Src_a,
    input  logic [AW-1:0]     Src_b,
    input  logic              Use_a,
    input  logic              Use_b,
    input  logic [AW-1:0]     Rf_addr,
    input  logic              Rf_we,
    input  logic              Dmem_we,
    input  logic              Out_flag,
    input  logic [DW+AW:0]    Wb_bus,
    output logic              Stall,
    output logic [OPW-1:0]    Buf2_opcode,
    output logic [DW-1:0]     Buf2_input1,
    output logic [DW-1:0]     Buf2_input2,
    output logic [AW-1:0]     Buf2_rf_addr,
    output logic              Buf2_rf_we,
    output logic              Buf2_dmem_we,
    output logic              Buf2_output,
    output logic              Flag_z,
    output logic              Flag_c
);
    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(2);
    localparam logic [OPW-1:0] OP_AND   = OPW'(3);
    localparam logic [OPW-1:0] OP_OR    = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR   = OPW'(5);
    localparam logic [OPW-1:0] OP_SHL   = OPW'(6);
    localparam logic [OPW-1:0] OP_SHR   = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL   = OPW'(8);
    localparam logic [OPW-1:0] OP_MOV   = OPW'(9);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(10);
    localparam logic [OPW-1:0] OP_STORE = OPW'(11);
    localparam logic [OPW-1:0] OP_INOUT = OPW'(12);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CW = $clog2(DW);

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   mul_a, mul_b;
    logic [2*DW-1:0] acc;
    logic [AW-1:0]   mul_rf_addr;
    logic            mul_rf_we;

    logic [DW-1:0] wb_data;
    logic [AW-1:0] wb_addr;
    logic          wb_we;
    assign {wb_data, wb_addr, wb_we} = Wb_bus;

    // LOAD and input-direction INOUT only produce their value in stage 3,
    // so Buf2 cannot forward them and a dependent instruction must stall.
    logic b2_late, b2_fwd, hazard;
    assign b2_late = (Buf2_opcode == OP_LOAD) | ((Buf2_opcode == OP_INOUT) & ~Buf2_output);
    assign b2_fwd  = Buf2_rf_we & ~b2_late;
    assign hazard  = Buf2_rf_we & b2_late &
                     ((Use_a & (Src_a == Buf2_rf_addr)) | (Use_b & (Src_b == Buf2_rf_addr)));

    // Buf2 is checked before Wb_bus because it holds the newer value.
    logic [DW-1:0] a, b;
    assign a = (Use_a & b2_fwd & (Src_a == Buf2_rf_addr)) ? Buf2_input1 :
               (Use_a & wb_we & (wb_addr == Src_a))       ? wb_data     : Op_a;
    assign b = (Use_b & b2_fwd & (Src_b == Buf2_rf_addr)) ? Buf2_input1 :
               (Use_b & wb_we & (wb_addr == Src_b))       ? wb_data     : Op_b;

    logic idle, done, mul_go, bubble;
    assign idle   = state == IDLE;
    assign done   = state == DONE;
    assign mul_go = idle & ~hazard & (Opcode == OP_MUL);
    assign Stall  = ~Rst & ((state == BUSY) | (idle & (hazard | (Opcode == OP_MUL))));
    assign bubble = Stall | (Opcode == OP_NOP);

    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          n_c, upd_z;
    assign sum   = (Opcode == OP_SUB) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
    assign res   = ((Opcode == OP_ADD) | (Opcode == OP_SUB)) ? sum[DW-1:0] :
                   (Opcode == OP_AND) ? a & b :
                   (Opcode == OP_OR)  ? a | b :
                   (Opcode == OP_XOR) ? a ^ b :
                   (Opcode == OP_SHL) ? a << 1 :
                   (Opcode == OP_SHR) ? a >> 1 : a;
    assign n_c   = ((Opcode == OP_ADD) | (Opcode == OP_SUB)) ? sum[DW] :
                   (Opcode == OP_SHL) ? a[DW-1] :
                   (Opcode == OP_SHR) ? a[0]    : Flag_c;
    assign upd_z = (Opcode >= OP_ADD) & (Opcode <= OP_SHR);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            acc          <= '0;
            mul_rf_addr  <= '0;
            mul_rf_we    <= 1'b0;
            Buf2_opcode  <= OP_NOP;
            Buf2_input1  <= '0;
            Buf2_input2  <= '0;
            Buf2_rf_addr <= '0;
            Buf2_rf_we   <= 1'b0;
            Buf2_dmem_we <= 1'b0;
            Buf2_output  <= 1'b0;
            Flag_z       <= 1'b0;
            Flag_c       <= 1'b0;
        end else begin
            state <= mul_go ? BUSY :
                     ((state == BUSY) & (cnt == CW'(DW-1))) ? DONE :
                     done ? IDLE : state;
            if (mul_go) begin
                mul_a       <= a;
                mul_b       <= b;
                acc         <= '0;
                cnt         <= '0;
                mul_rf_addr <= Rf_addr;
                mul_rf_we   <= Rf_we;
            end
            if (state == BUSY) begin
                acc <= acc + (mul_b[cnt] ? {{DW{1'b0}}, mul_a} << cnt : '0);
                cnt <= cnt + 1'b1;
            end
            Buf2_opcode  <= done ? OP_MUL : bubble ? OP_NOP : Opcode;
            Buf2_input1  <= done ? acc[DW-1:0] : bubble ? '0 : res;
            Buf2_input2  <= done ? mul_b : bubble ? '0 : b;
            Buf2_rf_addr <= done ? mul_rf_addr : bubble ? '0 : Rf_addr;
            Buf2_rf_we   <= done ? mul_rf_we : ~bubble & Rf_we;
            Buf2_dmem_we <= ~done & ~bubble & Dmem_we;
            Buf2_output  <= ~done & ~bubble & Out_flag;
            Flag_z       <= done ? (acc[DW-1:0] == '0) : (~bubble & upd_z) ? (res == '0) : Flag_z;
            Flag_c       <= done ? |acc[2*DW-1:DW] : ~bubble ? n_c : Flag_c;
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed vector table plus multiply and reset-abort sequences for exec_stage
module tb_exec_stage;
    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND = 4'd3, OR = 4'd4,
                           XOR = 4'd5, SHL = 4'd6, SHR = 4'd7, MUL = 4'd8, MOV = 4'd9,
                           LOAD = 4'd10, STORE = 4'd11, INOUT = 4'd12;

    logic       Clk, Rst;
    logic [3:0] Opcode;
    logic [7:0] Op_a, Op_b;
    logic [2:0] Src_a, Src_b, Rf_addr;
    logic       Use_a, Use_b, Rf_we, Dmem_we, Out_flag;
    logic [11:0] Wb_bus;
    logic       Stall;
    logic [3:0] Buf2_opcode;
    logic [7:0] Buf2_input1, Buf2_input2;
    logic [2:0] Buf2_rf_addr;
    logic       Buf2_rf_we, Buf2_dmem_we, Buf2_output, Flag_z, Flag_c;

    exec_stage dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Op_a(Op_a), .Op_b(Op_b),
        .Src_a(Src_a), .Src_b(Src_b), .Use_a(Use_a), .Use_b(Use_b),
        .Rf_addr(Rf_addr), .Rf_we(Rf_we), .Dmem_we(Dmem_we), .Out_flag(Out_flag),
        .Wb_bus(Wb_bus), .Stall(Stall), .Buf2_opcode(Buf2_opcode),
        .Buf2_input1(Buf2_input1), .Buf2_input2(Buf2_input2),
        .Buf2_rf_addr(Buf2_rf_addr), .Buf2_rf_we(Buf2_rf_we),
        .Buf2_dmem_we(Buf2_dmem_we), .Buf2_output(Buf2_output),
        .Flag_z(Flag_z), .Flag_c(Flag_c)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] op; logic [7:0] a, b; logic [2:0] sa, sb; logic ua, ub;
        logic [2:0] rd; logic we, dwe, of; logic [11:0] wb;
        logic st; logic [3:0] eop; logic [7:0] e1, e2; logic [2:0] erd;
        logic ewe, edwe, eout, ez, ec;
    } vec_t;

    vec_t tbl[22];
    int n_vec = 0, n_bad = 0;

    function automatic logic [11:0] wbf(input logic [7:0] d, input logic [2:0] ad, input logic w);
        return {d, ad, w};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        Opcode = x.op; Op_a = x.a; Op_b = x.b; Src_a = x.sa; Src_b = x.sb;
        Use_a = x.ua; Use_b = x.ub; Rf_addr = x.rd; Rf_we = x.we;
        Dmem_we = x.dwe; Out_flag = x.of; Wb_bus = x.wb;
    endtask

    task automatic run_mul(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] rd,
                           input logic [7:0] lo, input logic c, input logic z, input string tag);
        Opcode = MUL; Op_a = ma; Op_b = mb; Use_a = 1'b0; Use_b = 1'b0; Rf_addr = rd;
        Rf_we = 1'b1; Dmem_we = 1'b0; Out_flag = 1'b0; Wb_bus = '0;
        for (int k = 0; k < 9; k++) begin
            #1 chk($sformatf("%s.stall%0d", tag, k), int'(Stall), 1);
            if (k == 3) Op_a = 8'hFF;
            @(posedge Clk); #1;
            chk($sformatf("%s.we%0d", tag, k), int'(Buf2_rf_we), 0);
        end
        #1 chk($sformatf("%s.done_stall", tag), int'(Stall), 0);
        @(posedge Clk); #1;
        chk($sformatf("%s.lo", tag), int'(Buf2_input1), int'(lo));
        chk($sformatf("%s.c", tag), int'(Flag_c), int'(c));
        chk($sformatf("%s.z", tag), int'(Flag_z), int'(z));
        chk($sformatf("%s.op", tag), int'(Buf2_opcode), int'(MUL));
        chk($sformatf("%s.rd", tag), int'(Buf2_rf_addr), int'(rd));
        chk($sformatf("%s.rfwe", tag), int'(Buf2_rf_we), 1);
        Opcode = NOP;
    endtask

    initial begin
        tbl[0]  = '{ADD, 8'hF0, 8'h20, 0, 0, 0, 0, 3, 1, 0, 0, 12'h0,            0, ADD,   8'h10, 8'h20, 3, 1, 0, 0, 0, 1};
        tbl[1]  = '{ADD, 8'h05, 8'h03, 0, 0, 0, 0, 1, 1, 0, 0, 12'h0,            0, ADD,   8'h08, 8'h03, 1, 1, 0, 0, 0, 0};
        tbl[2]  = '{SUB, 8'h00, 8'h02, 1, 0, 1, 0, 4, 1, 0, 0, 12'h0,            0, SUB,   8'h06, 8'h02, 4, 1, 0, 0, 0, 0};
        tbl[3]  = '{AND, 8'h0F, 8'hF0, 0, 0, 0, 0, 5, 1, 0, 0, 12'h0,            0, AND,   8'h00, 8'hF0, 5, 1, 0, 0, 1, 0};
        tbl[4]  = '{OR,  8'h0F, 8'hF0, 0, 0, 0, 0, 5, 1, 0, 0, 12'h0,            0, OR,    8'hFF, 8'hF0, 5, 1, 0, 0, 0, 0};
        tbl[5]  = '{XOR, 8'hFF, 8'h0F, 0, 0, 0, 0, 5, 1, 0, 0, 12'h0,            0, XOR,   8'hF0, 8'h0F, 5, 1, 0, 0, 0, 0};
        tbl[6]  = '{SHL, 8'h81, 8'h00, 0, 0, 0, 0, 6, 1, 0, 0, 12'h0,            0, SHL,   8'h02, 8'h00, 6, 1, 0, 0, 0, 1};
        tbl[7]  = '{SHR, 8'h01, 8'h00, 0, 0, 0, 0, 6, 1, 0, 0, 12'h0,            0, SHR,   8'h00, 8'h00, 6, 1, 0, 0, 1, 1};
        tbl[8]  = '{MOV, 8'h5A, 8'h00, 0, 0, 0, 0, 6, 1, 0, 0, 12'h0,            0, MOV,   8'h5A, 8'h00, 6, 1, 0, 0, 1, 1};
        tbl[9]  = '{LOAD, 8'h00, 8'h40, 0, 0, 0, 0, 2, 1, 0, 0, 12'h0,           0, LOAD,  8'h00, 8'h40, 2, 1, 0, 0, 1, 1};
        tbl[10] = '{AND, 8'hFF, 8'h00, 0, 2, 0, 1, 7, 1, 0, 0, 12'h0,            1, NOP,   8'h00, 8'h00, 0, 0, 0, 0, 1, 1};
        tbl[11] = '{AND, 8'hFF, 8'h00, 0, 2, 0, 1, 7, 1, 0, 0, wbf(8'h3C, 2, 1), 0, AND,   8'h3C, 8'h3C, 7, 1, 0, 0, 0, 1};
        tbl[12] = '{STORE, 8'hAA, 8'h40, 0, 5, 0, 1, 0, 0, 1, 0, wbf(8'h41, 5, 1), 0, STORE, 8'hAA, 8'h41, 0, 0, 1, 0, 0, 1};
        tbl[13] = '{INOUT, 8'h00, 8'h00, 0, 0, 0, 0, 3, 1, 0, 0, 12'h0,          0, INOUT, 8'h00, 8'h00, 3, 1, 0, 0, 0, 1};
        tbl[14] = '{ADD, 8'h11, 8'h01, 3, 0, 1, 0, 4, 1, 0, 0, 12'h0,            1, NOP,   8'h00, 8'h00, 0, 0, 0, 0, 0, 1};
        tbl[15] = '{ADD, 8'h11, 8'h01, 3, 0, 1, 0, 4, 1, 0, 0, wbf(8'h77, 3, 1), 0, ADD,   8'h78, 8'h01, 4, 1, 0, 0, 0, 0};
        tbl[16] = '{ADD, 8'h10, 8'h10, 0, 0, 0, 0, 5, 1, 0, 0, 12'h0,            0, ADD,   8'h20, 8'h10, 5, 1, 0, 0, 0, 0};
        tbl[17] = '{SUB, 8'h00, 8'h01, 5, 0, 1, 0, 6, 1, 0, 0, wbf(8'h99, 5, 1), 0, SUB,   8'h1F, 8'h01, 6, 1, 0, 0, 0, 0};
        tbl[18] = '{SUB, 8'h00, 8'h01, 0, 0, 0, 0, 6, 1, 0, 0, 12'h0,            0, SUB,   8'hFF, 8'h01, 6, 1, 0, 0, 0, 1};
        tbl[19] = '{INOUT, 8'h33, 8'h00, 0, 0, 0, 0, 2, 1, 0, 1, 12'h0,          0, INOUT, 8'h33, 8'h00, 2, 1, 0, 1, 0, 1};
        tbl[20] = '{ADD, 8'h00, 8'h01, 2, 0, 1, 0, 1, 1, 0, 0, 12'h0,            0, ADD,   8'h34, 8'h01, 1, 1, 0, 0, 0, 0};
        tbl[21] = '{NOP, 8'h00, 8'h00, 0, 0, 0, 0, 3, 1, 1, 1, 12'h0,            0, NOP,   8'h00, 8'h00, 0, 0, 0, 0, 0, 0};

        Rst = 1'b1;
        drive(tbl[21]);
        Opcode = MUL;
        #2;
        chk("reset.stall", int'(Stall), 0);
        chk("reset.op", int'(Buf2_opcode), int'(NOP));
        chk("reset.rfwe", int'(Buf2_rf_we), 0);
        chk("reset.flags", int'({Flag_z, Flag_c}), 0);
        Opcode = NOP;
        @(posedge Clk); #1;
        Rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i]);
            #1 chk($sformatf("v%0d.stall", i), int'(Stall), int'(tbl[i].st));
            @(posedge Clk); #1;
            chk($sformatf("v%0d.op", i),   int'(Buf2_opcode),  int'(tbl[i].eop));
            chk($sformatf("v%0d.in1", i),  int'(Buf2_input1),  int'(tbl[i].e1));
            chk($sformatf("v%0d.in2", i),  int'(Buf2_input2),  int'(tbl[i].e2));
            chk($sformatf("v%0d.rd", i),   int'(Buf2_rf_addr), int'(tbl[i].erd));
            chk($sformatf("v%0d.we", i),   int'({Buf2_rf_we, Buf2_dmem_we, Buf2_output}),
                int'({tbl[i].ewe, tbl[i].edwe, tbl[i].eout}));
            chk($sformatf("v%0d.zc", i),   int'({Flag_z, Flag_c}), int'({tbl[i].ez, tbl[i].ec}));
        end

        run_mul(8'h12, 8'h10, 3'd1, 8'h20, 1'b1, 1'b0, "mul1");

        Opcode = MUL; Op_a = 8'h05; Op_b = 8'h07; Rf_addr = 3'd2; Rf_we = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("abort.stall%0d", k), int'(Stall), 1);
            @(posedge Clk); #1;
        end
        Rst = 1'b1;
        #1;
        chk("abort.stall", int'(Stall), 0);
        chk("abort.op", int'(Buf2_opcode), int'(NOP));
        chk("abort.data", int'({Buf2_input1, Buf2_input2, Buf2_rf_addr}), 0);
        chk("abort.we", int'({Buf2_rf_we, Buf2_dmem_we, Buf2_output}), 0);
        chk("abort.flags", int'({Flag_z, Flag_c}), 0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        run_mul(8'h03, 8'h04, 3'd4, 8'h0C, 1'b0, 1'b0, "mul2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
